// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//
// Memory stage of a simple pipeline. Non-memory instructions pass the ALU
// result through to WriteBack_data with one cycle of latency. Loads and
// stores go through a small IDLE -> BUSY -> DONE handshake with the data
// memory. An access to an address that is not word aligned is rejected
// without issuing a request.
//
// Optional feature (macro MEM_TIMEOUT_EN):
//   When defined, an access that stays in BUSY for TIMEOUT_CYCLES cycles
//   without mem_ack is aborted with err. When undefined, BUSY waits forever.
//
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles without mem_ack before abort (MEM_TIMEOUT_EN)
//
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   ALU_result_in   ALU result; load/store address when data_mem_en_in=1
//   WriteData_in    store data
//   data_mem_en_in  current instruction accesses memory
//   mem_write_in    1 = store, 0 = load
//   mem_req         data-memory request (high for exactly the BUSY cycles)
//   mem_we          write enable, valid with mem_req
//   mem_addr        word address, valid with mem_req
//   mem_wdata       store data, valid with mem_req
//   mem_rdata       load data, valid with mem_ack
//   mem_ack         memory completion strobe
//   stall           hold upstream stages (combinational)
//   WriteBack_data  registered result for the register file
//   done            one-cycle pulse at memory-op completion
//   err             one-cycle pulse on a misaligned or aborted access
// -----------------------------------------------------------------------------
module memory_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] WriteData_in,
    input  logic        data_mem_en_in,
    input  logic        mem_write_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] WriteBack_data,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q,   state_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q,  mem_we_d;
    logic [31:0]      addr_q,    addr_d;
    logic [31:0]      wdata_q,   wdata_d;
    logic [31:0]      wb_q,      wb_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;   // BUSY cycles already spent

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; that is what keeps this block from inferring latches.
        state_d   = state_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_d      = wb_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!data_mem_en_in) begin
                    wb_d = ALU_result_in;
                end else if (ALU_result_in[1:0] != 2'b00) begin
                    // Misaligned: reject without touching the memory bus.
                    state_d = DONE;
                    wb_d    = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d   = BUSY;
                    mem_req_d = 1'b1;
                    mem_we_d  = mem_write_in;
                    addr_d    = ALU_result_in;
                    wdata_d   = WriteData_in;
                    cnt_d     = '0;
                end
            end
            BUSY: begin
                // The ack is tested first so it wins over a timeout that
                // expires on the same cycle.
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!mem_we_q) wb_d = mem_rdata;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    wb_d      = '0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
`endif
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of its neighbours, independent of statement order.
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_q      <= wb_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign stall          = (state_q == BUSY) || ((state_q == IDLE) && data_mem_en_in);
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign WriteBack_data = wb_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
//
// Directed and randomized transactions against memory_access. The reference
// model works per transaction: it tracks the expected register-file value and
// derives each access's completion cycle, err flag and result from the
// address alignment, the ack delay and (with MEM_TIMEOUT_EN) the timeout.
// -----------------------------------------------------------------------------
module tb_memory_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu;
    logic [31:0] wd;
    logic        en;
    logic        we;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;
    logic [31:0] wb;
    logic        done;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wb_model;

    always #5 clk = ~clk;

    memory_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .ALU_result_in  (alu),
        .WriteData_in   (wd),
        .data_mem_en_in (en),
        .mem_write_in   (we),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (rdata),
        .mem_ack        (ack),
        .stall          (stall),
        .WriteBack_data (wb),
        .done           (done),
        .err            (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Non-memory instruction: result appears one edge later.
    task automatic do_pass(input logic [31:0] v);
        en    = 1'b0;
        alu   = v;
        wd    = $urandom;
        we    = 1'($urandom);
        ack   = 1'b1;            // must be ignored in IDLE
        rdata = $urandom;
        #1 check("pass stall", 32'(stall), 32'd0);
        tick();
        wb_model = v;
        check("pass wb", wb, wb_model);
        check("pass mem_req", 32'(mem_req), 32'd0);
        check("pass done", 32'(done), 32'd0);
        check("pass err", 32'(err), 32'd0);
    endtask

    // One load/store. ack_at = BUSY cycle (1-based) carrying mem_ack; 0 = never.
    task automatic do_access(input logic [31:0] addr, input logic we_v,
                             input logic [31:0] wdata, input int ack_at,
                             input logic [31:0] rdata_v);
        logic [31:0] exp_wb;
        logic        exp_err;
        int          k;
        bit          finished;
        exp_wb  = wb_model;
        exp_err = 1'b0;
        en    = 1'b1;
        alu   = addr;
        wd    = wdata;
        we    = we_v;
        ack   = 1'b1;            // must be ignored in IDLE
        rdata = $urandom;
        #1 check("req stall", 32'(stall), 32'd1);
        tick();
        if (addr[1:0] != 2'b00) begin
            exp_wb  = '0;
            exp_err = 1'b1;
        end else begin
            k        = 0;
            finished = 0;
            while (!finished) begin
                k++;
                check("busy mem_req", 32'(mem_req), 32'd1);
                check("busy mem_we", 32'(mem_we), 32'(we_v));
                check("busy mem_addr", mem_addr, addr);
                check("busy mem_wdata", mem_wdata, wdata);
                check("busy done", 32'(done), 32'd0);
                check("busy err", 32'(err), 32'd0);
                // Scramble the upstream inputs: the latched request must hold.
                en    = 1'($urandom);
                alu   = $urandom;
                wd    = $urandom;
                we    = 1'($urandom);
                ack   = (k == ack_at);
                rdata = (k == ack_at) ? rdata_v : $urandom;
                #1 check("busy stall", 32'(stall), 32'd1);
                tick();
                if (k == ack_at) begin
                    exp_wb   = we_v ? wb_model : rdata_v;
                    finished = 1;
`ifdef MEM_TIMEOUT_EN
                end else if (k == TO) begin
                    exp_wb   = '0;
                    exp_err  = 1'b1;
                    finished = 1;
`endif
                end else if (k >= 64) begin
                    checks++;
                    errors++;
                    $error("FAIL busy_budget: still busy after %0d cycles, required ack at %0d", k, ack_at);
                    finished = 1;
                end
            end
        end
        // DONE cycle
        check("done mem_req", 32'(mem_req), 32'd0);
        check("done done", 32'(done), 32'd1);
        check("done err", 32'(err), 32'(exp_err));
        check("done wb", wb, exp_wb);
        wb_model = exp_wb;
        en    = 1'b1;            // all inputs ignored in DONE
        alu   = $urandom;
        we    = 1'($urandom);
        ack   = 1'b1;
        rdata = $urandom;
        #1 check("done stall", 32'(stall), 32'd0);
        tick();
        check("after done", 32'(done), 32'd0);
        check("after err", 32'(err), 32'd0);
        check("after mem_req", 32'(mem_req), 32'd0);
        check("after wb", wb, wb_model);
    endtask

    task automatic reset_in_busy();
        en    = 1'b1;
        alu   = 32'h0000_0200;
        wd    = 32'h1357_9BDF;
        we    = 1'b1;
        ack   = 1'b0;
        tick();
        check("rstbusy mem_req before", 32'(mem_req), 32'd1);
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rstbusy mem_req", 32'(mem_req), 32'd0);
        check("rstbusy mem_addr", mem_addr, 32'd0);
        check("rstbusy wb", wb, 32'd0);
        check("rstbusy done", 32'(done), 32'd0);
        wb_model = '0;
        tick();
        rst = 1'b0;
        check("rstbusy held", 32'(mem_req), 32'd0);
        do_pass(32'hA5A5_0001);   // IDLE behaviour proves the access was discarded
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        we    = 1'b0;
        alu   = '0;
        wd    = '0;
        ack   = 1'b0;
        rdata = '0;
        #12;
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset wb", wb, 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        wb_model = '0;
        rst = 1'b0;

        do_pass(32'h0000_1234);
        do_access(32'h0000_0100, 1'b0, 32'h0, 2, 32'hCAFE_F00D);
        do_access(32'h0000_0104, 1'b1, 32'h55AA_55AA, 1, 32'hDEAD_BEEF);
        do_access(32'h0000_0102, 1'b0, 32'h0, 1, 32'h1111_1111);
`ifdef MEM_TIMEOUT_EN
        do_access(32'h0000_0108, 1'b0, 32'h0, 0, 32'h2222_2222);
        do_access(32'h0000_010C, 1'b0, 32'h0, TO, 32'h3333_3333);
`else
        do_access(32'h0000_0300, 1'b0, 32'h0, 10, 32'h4444_4444);
`endif
        reset_in_busy();

        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 3));
            a    = $urandom;
            if (kind == 0) begin
                do_pass(a);
            end else if (kind == 3) begin
                a[1:0] = 2'($urandom_range(1, 3));
                do_access(a, 1'($urandom), $urandom, 1, $urandom);
            end else begin
                a[1:0] = 2'b00;
                do_access(a, 1'($urandom), $urandom, int'($urandom_range(1, 5)), $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the BUSY cycles without mem_ack before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ALU_result_in  input  32  ALU result from Execution; this is the load/store address when data_mem_en_in=1.
REQ-005 SHALL have port WriteData_in  input  32  store data (rt operand).
REQ-006 SHALL have port data_mem_en_in  input  1  memory access requested by the current instruction.
REQ-007 SHALL have port mem_write_in  input  1  1=store, 0=load; valid with data_mem_en_in.
REQ-008 SHALL have port mem_req  output  1  data-memory request.
REQ-009 SHALL have port mem_we  output  1  write enable, valid with mem_req.
REQ-010 SHALL have port mem_addr  output  32  word address, valid with mem_req.
REQ-011 SHALL have port mem_wdata  output  32  store data, valid with mem_req.
REQ-012 SHALL have port mem_rdata  input  32  load data, valid with mem_ack.
REQ-013 SHALL have port mem_ack  input  1  memory completion strobe.
REQ-014 SHALL have port stall  output  1  hold upstream stages.
REQ-015 SHALL have port WriteBack_data  output  32  registered result for the register file.
REQ-016 SHALL have port done  output  1  one-cycle pulse marking memory-op completion.
REQ-017 SHALL have port err  output  1  one-cycle pulse on a misaligned or aborted access.

Function
REQ-018 SHALL implement the states IDLE, BUSY and DONE.
REQ-019 In IDLE with data_mem_en_in=0, SHALL register WriteBack_data<=ALU_result_in every cycle with stall=0 (pass-through, latency 1).
REQ-020 In IDLE with data_mem_en_in=1 and ALU_result_in[1:0]==0, SHALL latch address, data and mem_write_in and enter BUSY on that edge.
REQ-021 In IDLE with data_mem_en_in=1 and ALU_result_in[1:0]!=0, SHALL enter DONE without a request and set WriteBack_data=0; err SHALL pulse during the DONE cycle.
REQ-022 stall SHALL be combinational: 1 in BUSY, 1 in IDLE when data_mem_en_in=1, and 0 otherwise, including DONE.
REQ-023 mem_req SHALL be registered: 1 for exactly the BUSY cycles; mem_we/mem_addr/mem_wdata SHALL stay stable while mem_req=1.
REQ-024 In BUSY with mem_ack=1, SHALL drop mem_req on the next edge, enter DONE, and on a load capture mem_rdata into WriteBack_data; a store SHALL leave WriteBack_data unchanged.
REQ-025 mem_ack SHALL be ignored in IDLE and DONE.
REQ-026 In DONE, SHALL assert done=1 for one cycle, ignore all inputs, and return to IDLE.
REQ-027 Minimum access latency SHALL be 3 cycles from request to done: IDLE->BUSY, an ack on the first BUSY cycle, then DONE.

Reset
REQ-028 On rst=1, SHALL immediately force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, WriteBack_data=0, done=0, err=0, and timeout counter=0.
REQ-029 A reset asserted in BUSY SHALL drop mem_req within the same cycle and discard the access; no done or err pulse SHALL follow.

Configuration
REQ-030 With MEM_TIMEOUT_EN defined, SHALL count BUSY cycles; after TIMEOUT_CYCLES cycles without mem_ack, SHALL drop mem_req, set WriteBack_data=0, enter DONE, and pulse err with done.
REQ-031 With MEM_TIMEOUT_EN undefined, SHALL wait in BUSY indefinitely, and err SHALL come only from misalignment.
REQ-032 If mem_ack arrives on the same cycle the timeout expires, the ack SHALL win: normal completion, err=0.

Verification
REQ-033 Pass-through: en=0, ALU_result_in=0x0000_1234 -> WriteBack_data=0x0000_1234 next cycle, stall=0, no mem_req.
REQ-034 Load: en=1, we=0, addr=0x100, ack after 2 BUSY cycles with rdata=0xCAFE_F00D -> mem_req high for 2 cycles, WriteBack_data=0xCAFE_F00D, done for 1 cycle, stall low in DONE.
REQ-035 Store: en=1, we=1, addr=0x104, wdata=0x55AA_55AA, ack on the first BUSY cycle -> mem_we=1 and mem_wdata stable while mem_req=1; done on cycle 3; WriteBack_data unchanged.
REQ-036 Misaligned: addr=0x102, en=1 -> mem_req never asserts; err=1 and done=1 on the same cycle; WriteBack_data=0.
REQ-037 Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): no ack -> mem_req drops after 4 cycles; err=1 and done=1; WriteBack_data=0; an ack arriving on cycle 4 instead gives a normal completion.
REQ-038 Reset in BUSY: assert rst mid-access -> mem_req=0 immediately; state is IDLE after release; no done pulse.
